// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and oversampling constants
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

   localparam int         OS_RATE   = 16;
   localparam logic [3:0] MID_TICK  = 4'd7;
   localparam logic [3:0] LAST_TICK = 4'd15;

endpackage

// File: rtl/uart_rx_os_sync_2ff.sv
// rtl/uart_rx_os_sync_2ff.sv - two-flop synchroniser for a single async input
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture; reset value matches the idle level of the line
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x oversampling UART receiver with optional parity
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 os_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int             BW       = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

   logic                 w_rx_s;
   logic                 w_par_exp;

   uart_state_t          r_state;
   logic [3:0]           r_tick;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_par_bad;
   logic                 r_valid;
   logic                 r_ferr;
   logic                 r_perr;
   logic                 r_busy;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (rx),
      .o_q     (w_rx_s)
   );

   // Parity bit the transmitter should have sent for the bits shifted in so far
   assign w_par_exp = (^r_shift) ^ (PARITY_ODD != 0);

   // Frame FSM: counters only move on os_tick, strobes are one clock wide
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_tick    <= 4'd0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_par_bad <= 1'b0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_perr    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_perr  <= 1'b0;
         if (os_tick) begin
            case (r_state)
               IDLE: begin
                  if (!w_rx_s) begin
                     r_state <= START;
                     r_tick  <= 4'd0;
                  end
               end
               START: begin
                  if (r_tick == MID_TICK) begin
                     r_tick <= 4'd0;
                     if (!w_rx_s) begin
                        r_state   <= DATA;
                        r_bit     <= '0;
                        r_busy    <= 1'b1;
                        r_par_bad <= 1'b0;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_tick <= r_tick + 4'd1;
                  end
               end
               DATA: begin
                  if (r_tick == LAST_TICK) begin
                     r_tick  <= 4'd0;
                     r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                     r_bit   <= r_bit + BW'(1);
                     if (r_bit == LAST_BIT) begin
                        r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                     end
                  end else begin
                     r_tick <= r_tick + 4'd1;
                  end
               end
               PARITY: begin
                  if (r_tick == LAST_TICK) begin
                     r_tick    <= 4'd0;
                     r_par_bad <= (w_rx_s != w_par_exp);
                     r_state   <= STOP;
                  end else begin
                     r_tick <= r_tick + 4'd1;
                  end
               end
               STOP: begin
                  if (r_tick == LAST_TICK) begin
                     r_tick  <= 4'd0;
                     r_data  <= r_shift;
                     r_busy  <= 1'b0;
                     r_valid <= w_rx_s & ~r_par_bad;
                     r_ferr  <= ~w_rx_s;
                     r_perr  <= r_par_bad;
                     r_state <= w_rx_s ? IDLE : BREAK;
                  end else begin
                     r_tick <= r_tick + 4'd1;
                  end
               end
               BREAK: begin
                  if (w_rx_s) begin
                     r_state <= IDLE;
                  end
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign frame_err  = r_ferr;
   assign parity_err = r_perr;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed bench for uart_rx_os (8N1 and 8E1 instances)
module tb_uart_rx_os;

   localparam int TICK_DIV = 27;
   localparam int BIT_CLK  = 16 * TICK_DIV;

   logic       clk;
   logic       reset;
   logic       os_tick;
   logic       rx_a;
   logic       rx_b;
   logic [7:0] data_out_a;
   logic [7:0] data_out_b;
   logic       data_valid_a, frame_err_a, parity_err_a, busy_a;
   logic       data_valid_b, frame_err_b, parity_err_b, busy_b;

   int n_vec;
   int n_bad;

   int n_val_a, n_rise_a, n_ferr_a, n_perr_a, n_busy_a;
   int n_val_b, n_ferr_b, n_perr_b;
   logic prev_val_a;
   logic [7:0] q_a[$];
   int tick_cnt;

   uart_rx_os #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .os_tick    (os_tick),
      .rx         (rx_a),
      .data_out   (data_out_a),
      .data_valid (data_valid_a),
      .frame_err  (frame_err_a),
      .parity_err (parity_err_a),
      .busy       (busy_a)
   );

   uart_rx_os #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .clk        (clk),
      .reset      (reset),
      .os_tick    (os_tick),
      .rx         (rx_b),
      .data_out   (data_out_b),
      .data_valid (data_valid_b),
      .frame_err  (frame_err_b),
      .parity_err (parity_err_b),
      .busy       (busy_b)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // 16x tick, one clock wide every TICK_DIV clocks
   initial begin
      os_tick  = 1'b0;
      tick_cnt = 0;
      forever begin
         @(negedge clk);
         tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
         os_tick  = (tick_cnt == TICK_DIV - 1);
      end
   end

   // Output monitors, sampled away from the active edge
   initial begin
      n_val_a = 0; n_rise_a = 0; n_ferr_a = 0; n_perr_a = 0; n_busy_a = 0;
      n_val_b = 0; n_ferr_b = 0; n_perr_b = 0;
      prev_val_a = 1'b0;
      forever begin
         @(negedge clk);
         if (data_valid_a) begin
            n_val_a++;
            q_a.push_back(data_out_a);
         end
         if (data_valid_a && !prev_val_a) n_rise_a++;
         prev_val_a = data_valid_a;
         if (frame_err_a)  n_ferr_a++;
         if (parity_err_a) n_perr_a++;
         if (busy_a)       n_busy_a++;
         if (data_valid_b) n_val_b++;
         if (frame_err_b)  n_ferr_b++;
         if (parity_err_b) n_perr_b++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bit_time(input bit sel, input logic v, input int clks);
      if (sel) rx_b = v;
      else     rx_a = v;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                             input logic par, input logic stop);
      bit_time(sel, 1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) bit_time(sel, d[i], BIT_CLK);
      if (has_par) bit_time(sel, par, BIT_CLK);
      bit_time(sel, stop, BIT_CLK);
   endtask

   function automatic logic [7:0] pop_a();
      logic [7:0] v;
      if (q_a.size() == 0) return 8'hxx;
      v = q_a.pop_front();
      return v;
   endfunction

   initial begin
      int v0, r0, f0, p0, b0, vb0, fb0, pb0;
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      rx_a  = 1'b1;
      rx_b  = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_data",  {24'd0, data_out_a}, 32'h0);
      check("rst_valid", {31'd0, data_valid_a}, 32'h0);
      check("rst_busy",  {31'd0, busy_a}, 32'h0);
      check("rst_ferr",  {31'd0, frame_err_a}, 32'h0);
      reset = 1'b0;
      repeat (BIT_CLK) @(negedge clk);

      // 1: plain 8N1 frame
      v0 = n_val_a; r0 = n_rise_a; f0 = n_ferr_a; b0 = n_busy_a;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      repeat (BIT_CLK) @(negedge clk);
      check("t1_valid_cnt", n_val_a - v0, 1);
      check("t1_valid_width", n_rise_a - r0, 1);
      check("t1_ferr", n_ferr_a - f0, 0);
      check("t1_data", {24'd0, pop_a()}, 32'hA5);
      check("t1_busy_seen", (n_busy_a - b0) > 0, 1);
      check("t1_busy_after", {31'd0, busy_a}, 32'h0);

      // 2: false start glitch, then a good frame
      v0 = n_val_a; b0 = n_busy_a; f0 = n_ferr_a;
      bit_time(1'b0, 1'b0, 5 * TICK_DIV);
      bit_time(1'b0, 1'b1, 2 * BIT_CLK);
      check("t2_no_busy", n_busy_a - b0, 0);
      check("t2_no_valid", n_val_a - v0, 0);
      check("t2_no_ferr", n_ferr_a - f0, 0);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      repeat (BIT_CLK) @(negedge clk);
      check("t2_valid", n_val_a - v0, 1);
      check("t2_data", {24'd0, pop_a()}, 32'h3C);

      // 3: framing error followed by a long break
      v0 = n_val_a; f0 = n_ferr_a;
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      b0 = n_busy_a;
      bit_time(1'b0, 1'b0, 20 * BIT_CLK);
      check("t3_ferr", n_ferr_a - f0, 1);
      check("t3_no_valid", n_val_a - v0, 0);
      check("t3_break_busy", n_busy_a - b0, 0);
      check("t3_data_loaded", {24'd0, data_out_a}, 32'h3C);
      bit_time(1'b0, 1'b1, BIT_CLK);
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      repeat (BIT_CLK) @(negedge clk);
      check("t3_valid_after", n_val_a - v0, 1);
      check("t3_ferr_once", n_ferr_a - f0, 1);
      check("t3_data", {24'd0, pop_a()}, 32'h55);

      // 4: even parity instance
      vb0 = n_val_b; pb0 = n_perr_b; fb0 = n_ferr_b;
      send_frame(1'b1, 8'h0F, 1'b1, 1'b0, 1'b1);
      repeat (BIT_CLK) @(negedge clk);
      check("t4_good_valid", n_val_b - vb0, 1);
      check("t4_good_perr", n_perr_b - pb0, 0);
      check("t4_good_data", {24'd0, data_out_b}, 32'h0F);
      send_frame(1'b1, 8'h0F, 1'b1, 1'b1, 1'b1);
      repeat (BIT_CLK) @(negedge clk);
      check("t4_bad_valid", n_val_b - vb0, 1);
      check("t4_bad_perr", n_perr_b - pb0, 1);
      check("t4_bad_ferr", n_ferr_b - fb0, 0);

      // 5: back-to-back frames with no idle gap
      v0 = n_val_a;
      send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      repeat (BIT_CLK) @(negedge clk);
      check("t5_valid_cnt", n_val_a - v0, 2);
      check("t5_first", {24'd0, pop_a()}, 32'h00);
      check("t5_second", {24'd0, pop_a()}, 32'hFF);

      // 6: reset in the middle of data bit 3 of 0x12
      v0 = n_val_a; f0 = n_ferr_a;
      bit_time(1'b0, 1'b0, BIT_CLK);
      bit_time(1'b0, 1'b0, BIT_CLK);
      bit_time(1'b0, 1'b1, BIT_CLK);
      bit_time(1'b0, 1'b0, BIT_CLK);
      bit_time(1'b0, 1'b0, BIT_CLK / 2);
      check("t6_busy_pre", {31'd0, busy_a}, 32'h1);
      reset = 1'b1;
      rx_a  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_rst_data", {24'd0, data_out_a}, 32'h0);
      check("t6_rst_busy", {31'd0, busy_a}, 32'h0);
      check("t6_rst_valid", {31'd0, data_valid_a}, 32'h0);
      repeat (2 * BIT_CLK) @(negedge clk);
      check("t6_no_strobe", (n_val_a - v0) + (n_ferr_a - f0), 0);
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
      repeat (BIT_CLK) @(negedge clk);
      check("t6_valid", n_val_a - v0, 1);
      check("t6_data", {24'd0, pop_a()}, 32'h81);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
